// File: rtl/wb_hmem.sv
// Wishbone-attached 2**ADDR_WIDTH x 16-bit halfword memory with byte-lane writes.
// WAIT_STATES extra cycles before a one-cycle ack/err, followed by one recovery cycle.
module wb_hmem #(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [15:0] mem [DEPTH];

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    hit_q, hit_d;
  logic [15:0]             wdat_q, wdat_d;
  logic [1:0]              sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [15:0]             rdat_q, rdat_d;
  logic                    enter_ack;
  logic                    mem_we;
  logic                    req;
  logic                    in_hit;
  logic [ADDR_WIDTH-1:0]   in_idx;
  logic                    unused_adr0;

  assign req         = wb_cyc_i & wb_stb_i;
  assign in_hit      = (wb_adr_i[31:ADDR_WIDTH+1] == BASE[31:ADDR_WIDTH+1]);
  assign in_idx      = wb_adr_i[ADDR_WIDTH:1];
  assign unused_adr0 = wb_adr_i[0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    wdat_d    = wdat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdat_d    = rdat_q;
    enter_ack = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d  = in_idx;
          hit_d  = in_hit;
          wdat_d = wb_dat_i;
          sel_d  = wb_sel_i;
          we_d   = wb_we_i;
          if (WAIT_STATES == 0) begin
            state_d   = S_ACK;
            enter_ack = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A master that withdraws mid-wait abandons the access silently.
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d   = S_ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:     state_d = S_RECOVER;
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // The *_d request fields equal the latched ones in WAIT and the live bus in IDLE.
    if (enter_ack) begin
      ack_d = hit_d;
      err_d = ~hit_d;
      if (hit_d && !we_d) begin
        rdat_d = mem[idx_d];
      end
    end
  end

  assign mem_we = enter_ack & hit_d & we_d & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      if (sel_d[1]) mem[idx_d][15:8] <= wdat_d[15:8];
      if (sel_d[0]) mem[idx_d][7:0]  <= wdat_d[7:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      wdat_q  <= 16'h0000;
      sel_q   <= 2'b00;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_hmem.sv
// Scoreboard bench for wb_hmem: three instances (1, 3 and 0 wait states) share one bus,
// with cyc/stb steered to the instance under test.
module tb_wb_hmem;

  typedef struct {
    logic        err;
    logic [15:0] dat;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [15:0] wdat;
  logic [1:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  int          dsel;
  logic [2:0]  cyc_v, stb_v;
  logic [15:0] dat_o [3];
  logic [2:0]  ack_o, err_o;

  int          wsv [3] = '{1, 3, 0};
  exp_t        exp_q [$];
  exp_t        e;
  logic [15:0] mdl [int];
  logic [15:0] last_dat [3];
  int          ack_cnt [3];
  int          both_cnt;
  int          checks;
  int          errors;
  logic        got_ack, got_err;
  logic [15:0] got_dat;
  int          got_lat;

  assign cyc_v = cyc ? (3'b001 << dsel) : 3'b000;
  assign stb_v = stb ? (3'b001 << dsel) : 3'b000;

  wb_hmem #(.WAIT_STATES(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_o[0]),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc_v[0]), .wb_stb_i(stb_v[0]),
    .wb_ack_o(ack_o[0]), .wb_err_o(err_o[0]));

  wb_hmem #(.WAIT_STATES(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_o[1]),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc_v[1]), .wb_stb_i(stb_v[1]),
    .wb_ack_o(ack_o[1]), .wb_err_o(err_o[1]));

  wb_hmem #(.WAIT_STATES(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_o[2]),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc_v[2]), .wb_stb_i(stb_v[2]),
    .wb_ack_o(ack_o[2]), .wb_err_o(err_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ack_o[k]) ack_cnt[k] = ack_cnt[k] + 1;
      if (ack_o[k] && err_o[k]) both_cnt = both_cnt + 1;
    end
  end

  // Pushes the expected termination, runs one bus transfer and captures what came back.
  // hold keeps cyc/stb high through recovery; scr scrambles the bus after sampling.
  task automatic do_xfer(input int d, input logic w, input logic [31:0] a,
                         input logic [15:0] wd, input logic [1:0] s,
                         input logic hold, input logic scr);
    exp_t        x;
    int          key;
    logic [15:0] cur;
    key   = d * 65536 + int'(a[12:1]);
    x.lat = wsv[d] + 1;
    x.err = (a[31:13] != 19'd0);
    x.dat = last_dat[d];
    if (!x.err) begin
      if (w) begin
        cur = mdl.exists(key) ? mdl[key] : 16'h0000;
        if (s[1]) cur[15:8] = wd[15:8];
        if (s[0]) cur[7:0]  = wd[7:0];
        mdl[key] = cur;
      end else begin
        x.dat = mdl[key];
      end
    end
    last_dat[d] = x.dat;
    exp_q.push_back(x);

    @(negedge clk);
    dsel = d; adr = a; wdat = wd; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    if (scr) begin
      #1;
      adr = a ^ 32'h0000_0006; wdat = ~wd; sel = ~s; we = ~w;
    end
    got_ack = 1'b0; got_err = 1'b0; got_dat = 16'hxxxx; got_lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack_o[d] || err_o[d]) begin
        got_ack = ack_o[d]; got_err = err_o[d]; got_dat = dat_o[d]; got_lat = i;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      cyc = 1'b0; stb = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; dsel = 0;
    adr = '0; wdat = '0; sel = '0; we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ack_o !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b expected 000", ack_o); end
    checks++;
    if (err_o !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", err_o); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dat_o[k] !== 16'h0000) begin
        errors++; $display("FAIL reset_dat%0d: got %h expected 0000", k, dat_o[k]);
      end
      last_dat[k] = 16'h0000;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_xfer(0, 1'b1, 32'h0000_0004, 16'hBEEF, 2'b11, 1'b0, 1'b0);
    e = exp_q.pop_front(); checks++;
    if ({got_ack, got_err, got_dat, got_lat} !== {~e.err, e.err, e.dat, e.lat}) begin
      errors++;
      $display("FAIL basic_wr: got ack=%0b err=%0b dat=%h lat=%0d expected ack=%0b err=%0b dat=%h lat=%0d",
               got_ack, got_err, got_dat, got_lat, ~e.err, e.err, e.dat, e.lat);
    end
    do_xfer(0, 1'b0, 32'h0000_0004, 16'h0000, 2'b11, 1'b0, 1'b0);
    e = exp_q.pop_front(); checks++;
    if ({got_ack, got_err, got_dat, got_lat} !== {~e.err, e.err, e.dat, e.lat}) begin
      errors++;
      $display("FAIL basic_rd: got ack=%0b err=%0b dat=%h lat=%0d expected ack=%0b err=%0b dat=%h lat=%0d",
               got_ack, got_err, got_dat, got_lat, ~e.err, e.err, e.dat, e.lat);
    end
  endtask

  task automatic test_lanes();
    logic        tw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] td [4] = '{16'h12AA, 16'h0000, 16'hFFFF, 16'h0000};
    logic [1:0]  ts [4] = '{2'b10, 2'b11, 2'b00, 2'b11};
    for (int i = 0; i < 4; i++) begin
      do_xfer(0, tw[i], 32'h0000_0004, td[i], ts[i], 1'b0, 1'b0);
      e = exp_q.pop_front(); checks++;
      if ({got_ack, got_err, got_dat, got_lat} !== {~e.err, e.err, e.dat, e.lat}) begin
        errors++;
        $display("FAIL lanes_%0d: got ack=%0b err=%0b dat=%h lat=%0d expected ack=%0b err=%0b dat=%h lat=%0d",
                 i, got_ack, got_err, got_dat, got_lat, ~e.err, e.err, e.dat, e.lat);
      end
    end
  endtask

  task automatic test_out_of_range();
    int c0;
    c0 = ack_cnt[0];
    do_xfer(0, 1'b0, 32'h0000_4000, 16'h0000, 2'b11, 1'b0, 1'b0);
    e = exp_q.pop_front(); checks++;
    if ({got_ack, got_err, got_dat, got_lat} !== {~e.err, e.err, e.dat, e.lat}) begin
      errors++;
      $display("FAIL oor_read: got ack=%0b err=%0b dat=%h lat=%0d expected ack=%0b err=%0b dat=%h lat=%0d",
               got_ack, got_err, got_dat, got_lat, ~e.err, e.err, e.dat, e.lat);
    end
    do_xfer(0, 1'b1, 32'h8000_0004, 16'h0BAD, 2'b11, 1'b0, 1'b0);
    e = exp_q.pop_front();
    do_xfer(0, 1'b0, 32'h0000_0004, 16'h0000, 2'b11, 1'b0, 1'b0);
    e = exp_q.pop_front(); checks++;
    if ({got_ack, got_dat, ack_cnt[0] - c0} !== {1'b1, e.dat, 32'sd1}) begin
      errors++;
      $display("FAIL oor_nowrite: got ack=%0b dat=%h acks=%0d expected ack=1 dat=%h acks=1",
               got_ack, got_dat, ack_cnt[0] - c0, e.dat);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    for (int i = 0; i < 16; i++) begin
      do_xfer(0, 1'b1, 32'(i * 2), 16'(16'hA050 + i * 16'h0107), 2'b11, 1'b1, 1'b0);
      e = exp_q.pop_front();
    end
    c0 = ack_cnt[0];
    for (int i = 0; i < 16; i++) begin
      do_xfer(0, 1'b0, 32'(i * 2), 16'h0000, 2'b11, 1'b1, 1'b0);
      e = exp_q.pop_front(); checks++;
      if ({got_ack, got_err, got_dat, got_lat} !== {~e.err, e.err, e.dat, e.lat}) begin
        errors++;
        $display("FAIL b2b_rd%0d: got ack=%0b err=%0b dat=%h lat=%0d expected ack=%0b err=%0b dat=%h lat=%0d",
                 i, got_ack, got_err, got_dat, got_lat, ~e.err, e.err, e.dat, e.lat);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (ack_cnt[0] - c0 != 16) begin
      errors++; $display("FAIL b2b_count: got %0d acks expected 16", ack_cnt[0] - c0);
    end
  endtask

  task automatic test_zero_wait();
    do_xfer(2, 1'b1, 32'h0000_0100, 16'hC0DE, 2'b11, 1'b0, 1'b0);
    e = exp_q.pop_front(); checks++;
    if ({got_ack, got_err, got_lat} !== {~e.err, e.err, e.lat}) begin
      errors++;
      $display("FAIL ws0_wr: got ack=%0b err=%0b lat=%0d expected ack=1 err=0 lat=%0d", got_ack, got_err, got_lat, e.lat);
    end
    do_xfer(2, 1'b0, 32'h0000_0100, 16'h0000, 2'b11, 1'b0, 1'b0);
    e = exp_q.pop_front(); checks++;
    if ({got_ack, got_err, got_dat, got_lat} !== {~e.err, e.err, e.dat, e.lat}) begin
      errors++;
      $display("FAIL ws0_rd: got ack=%0b err=%0b dat=%h lat=%0d expected ack=%0b err=%0b dat=%h lat=%0d",
               got_ack, got_err, got_dat, got_lat, ~e.err, e.err, e.dat, e.lat);
    end
  endtask

  task automatic test_drop_stb();
    int c0;
    do_xfer(1, 1'b1, 32'h0000_0020, 16'h7777, 2'b11, 1'b0, 1'b0);
    e = exp_q.pop_front();
    c0 = ack_cnt[1];
    @(negedge clk);
    dsel = 1; adr = 32'h0000_0020; wdat = 16'h5A5A; sel = 2'b11; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk);
    do_xfer(1, 1'b0, 32'h0000_0020, 16'h0000, 2'b11, 1'b0, 1'b0);
    e = exp_q.pop_front(); checks++;
    if ({got_ack, got_err, got_dat, got_lat} !== {~e.err, e.err, e.dat, e.lat}) begin
      errors++;
      $display("FAIL drop_rd: got ack=%0b err=%0b dat=%h lat=%0d expected ack=%0b err=%0b dat=%h lat=%0d",
               got_ack, got_err, got_dat, got_lat, ~e.err, e.err, e.dat, e.lat);
    end
    checks++;
    if (ack_cnt[1] - c0 != 1) begin
      errors++; $display("FAIL drop_acks: got %0d acks expected 1", ack_cnt[1] - c0);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_xfer(1, 1'b1, 32'h0000_0010, 16'hA0A0, 2'b11, 1'b0, 1'b0);
    e = exp_q.pop_front();
    do_xfer(1, 1'b0, 32'h0000_0010, 16'h0000, 2'b11, 1'b0, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (got_dat !== 16'hA0A0) begin
      errors++; $display("FAIL rstmid_pre: got %h expected a0a0", got_dat);
    end
    @(negedge clk);
    dsel = 1; adr = 32'h0000_0010; wdat = 16'h5555; sel = 2'b11; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dat_o[1], ack_o, err_o} !== {16'h0000, 3'b000, 3'b000}) begin
      errors++; $display("FAIL rstmid_clear: got dat=%h ack=%b err=%b expected dat=0000 ack=000 err=000",
                         dat_o[1], ack_o, err_o);
    end
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    for (int k = 0; k < 3; k++) last_dat[k] = 16'h0000;
    do_xfer(1, 1'b0, 32'h0000_0010, 16'h0000, 2'b11, 1'b0, 1'b0);
    e = exp_q.pop_front(); checks++;
    if ({got_ack, got_err, got_dat, got_lat} !== {~e.err, e.err, e.dat, e.lat}) begin
      errors++;
      $display("FAIL rstmid_rd: got ack=%0b err=%0b dat=%h lat=%0d expected ack=%0b err=%0b dat=%h lat=%0d",
               got_ack, got_err, got_dat, got_lat, ~e.err, e.err, e.dat, e.lat);
    end
  endtask

  task automatic test_latched_request();
    do_xfer(1, 1'b1, 32'h0000_0030, 16'h1357, 2'b11, 1'b0, 1'b1);
    e = exp_q.pop_front(); checks++;
    if ({got_ack, got_err, got_lat} !== {~e.err, e.err, e.lat}) begin
      errors++;
      $display("FAIL latch_wr: got ack=%0b err=%0b lat=%0d expected ack=1 err=0 lat=%0d", got_ack, got_err, got_lat, e.lat);
    end
    do_xfer(1, 1'b0, 32'h0000_0030, 16'h0000, 2'b11, 1'b0, 1'b0);
    e = exp_q.pop_front(); checks++;
    if ({got_ack, got_err, got_dat, got_lat} !== {~e.err, e.err, e.dat, e.lat}) begin
      errors++;
      $display("FAIL latch_rd: got ack=%0b err=%0b dat=%h lat=%0d expected ack=%0b err=%0b dat=%h lat=%0d",
               got_ack, got_err, got_dat, got_lat, ~e.err, e.err, e.dat, e.lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; both_cnt = 0;
    for (int k = 0; k < 3; k++) ack_cnt[k] = 0;
    test_reset();
    test_basic();
    test_lanes();
    test_out_of_range();
    test_back_to_back();
    test_zero_wait();
    test_drop_stb();
    test_reset_mid_wait();
    test_latched_request();
    checks++;
    if (both_cnt != 0) begin
      errors++; $display("FAIL ack_and_err: got %0d cycles with both expected 0", both_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
